temporal_compare_n: RTL
=======================

TEMPORAL_COMPARE_N -- requirements
Module: temporal_compare_n

Interface
REQ-001 SHALL provide parameter N, default 4: number of spike input channels, N >= 2.
REQ-002 SHALL provide parameter GAMMA_CYCLE_WIDTH, default 16: aclk cycles per gamma cycle, >= 2.
REQ-003 SHALL derive TW = $clog2(GAMMA_CYCLE_WIDTH)+1 and IW = $clog2(N).
REQ-004 SHALL have port aclk  input  1  the single clock; all state updates on posedge.
REQ-005 SHALL have port grst  input  1  synchronous, active-high reset that also starts a new gamma cycle.
REQ-006 SHALL have port mode  input  2  comparison mode: 0 MIN, 1 MAX, 2 INHIBIT, 3 reserved.
REQ-007 SHALL have port in_spk  input  N  per-channel spike level, synchronous to aclk; a 0->1 transition is a spike.
REQ-008 SHALL have port q  output  1  temporal result, registered; once high it holds until grst.
REQ-009 SHALL have port q_time  output  TW  gamma-counter value at which q fired; all-ones means no spike.
REQ-010 SHALL have port q_idx  output  IW  channel that produced q; 0 when q never fires.
REQ-011 SHALL have port valid  output  1  one-cycle pulse marking the end of the gamma cycle.

Function
REQ-012 SHALL keep a gamma counter cnt (TW bits): 0 on any posedge with grst=1, +1 per posedge otherwise, saturating at GAMMA_CYCLE_WIDTH-1.
REQ-013 SHALL have states ARMED and DONE: grst -> ARMED; ARMED with cnt==GAMMA_CYCLE_WIDTH-1 -> DONE; DONE holds until grst.
REQ-014 SHALL latch mode on every posedge with grst=1 and hold it for the gamma cycle; mode changes while grst=0 have no effect.
REQ-015 SHALL detect a spike on channel i at a posedge where grst=0, state=ARMED, sampled in_spk[i]=1 and the previous sample=0.
REQ-016 SHALL load the previous-sample register with in_spk during grst, so a level already high at reset is not a spike.
REQ-017 SHALL record each channel's first spike only; later transitions on that channel in the same gamma cycle are ignored.
REQ-018 SHALL ignore all spikes in DONE.
REQ-019 SHALL set q on the same posedge that detects the qualifying spike (one-register latency), with q_time = cnt at that posedge.
REQ-020 MIN SHALL fire on the first spike on any channel; on simultaneous spikes q_idx = lowest index.
REQ-021 MAX SHALL fire when the last of all N channels has spiked; q_idx = lowest index among the channels spiking on that posedge.
REQ-022 INHIBIT SHALL fire only if channel 0 spikes strictly before every other channel, with q_idx=0.
REQ-023 INHIBIT SHALL never fire in that gamma cycle if any channel 1..N-1 spikes before or on the same posedge as channel 0.
REQ-024 Mode 3 SHALL never fire q; valid still pulses.
REQ-025 SHALL fire q at most once per gamma cycle; q_time and q_idx are frozen once q is set.
REQ-026 SHALL set valid on the posedge where state=ARMED and cnt==GAMMA_CYCLE_WIDTH-1, and clear it on the next posedge.
REQ-027 SHALL count a spike detected on the posedge with cnt==GAMMA_CYCLE_WIDTH-1 before the transition to DONE.
REQ-028 SHALL hold q, q_time and q_idx stable while valid=1 and throughout DONE.

Reset
REQ-029 SHALL, on any posedge with grst=1, set q=0, q_time=all-ones, q_idx=0, valid=0, cnt=0 and state=ARMED.
REQ-030 SHALL abort an in-progress gamma cycle when grst asserts mid-cycle: no valid pulse for the aborted cycle, and all recorded spikes are cleared.

Verification (N=4, GAMMA_CYCLE_WIDTH=16)
REQ-031 SHALL check: MIN, no spikes for 16 cycles -> q=0 throughout; valid pulses once after the cnt=15 posedge; q_time=31, q_idx=0.
REQ-032 SHALL check: MIN, ch2 spike at cnt=3 and ch0 at cnt=5 -> q high after the cnt=3 posedge; q_idx=2, q_time=3; ch0 spike has no effect.
REQ-033 SHALL check the three INHIBIT cases:
- ch0 at cnt=2, ch1 at cnt=4 -> q=1, q_time=2.
- ch1 at cnt=2, ch0 at cnt=4 -> q=0 all cycle.
- ch0 and ch1 both at cnt=3 -> q=0 all cycle.
REQ-034 SHALL check: MAX, spikes ch0@1, ch1@7, ch2@4, ch3@9 -> q rises at cnt=9; q_idx=3, q_time=9.
REQ-035 SHALL check: grst asserted at cnt=6 after q fired -> next cycle q=0, q_time=31, cnt=0; no valid pulse for the aborted cycle.
REQ-036 SHALL check: ch1 held high across grst with mode=MIN -> no spike detected; a ch1 fall then rise at cnt=5 -> q_time=5, q_idx=1.

Source files
------------

// File: rtl/temporal_compare_n.sv
`default_nettype none
// ============================================================================
//  Module      : temporal_compare_n
//  Description : N-channel temporal comparator over one gamma cycle.
//                Records the first rising edge of each spike channel and
//                fires a single registered result according to the latched
//                mode (MIN / MAX / INHIBIT), reporting when and which channel.
//  Revision    : 1.0 - initial release
// ============================================================================
module temporal_compare_n #(
  parameter int N                 = 4,
  parameter int GAMMA_CYCLE_WIDTH = 16,
  localparam int TW               = $clog2(GAMMA_CYCLE_WIDTH) + 1,
  localparam int IW               = $clog2(N)
) (
  input  logic          aclk,
  input  logic          grst,
  input  logic [1:0]    mode,
  input  logic [N-1:0]  in_spk,
  output logic          q,
  output logic [TW-1:0] q_time,
  output logic [IW-1:0] q_idx,
  output logic          valid
);

  localparam logic [TW-1:0] LAST_CNT = TW'(GAMMA_CYCLE_WIDTH - 1);
  localparam logic [1:0]    MODE_MIN = 2'd0;
  localparam logic [1:0]    MODE_MAX = 2'd1;
  localparam logic [1:0]    MODE_INH = 2'd2;

  typedef enum logic [0:0] {
    ARMED = 1'b0,
    DONE  = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [1:0]    mode_q, mode_d;
  logic [N-1:0]  prev_q, prev_d;
  logic [N-1:0]  seen_q, seen_d;
  logic          q_q, q_d;
  logic [TW-1:0] q_time_q, q_time_d;
  logic [IW-1:0] q_idx_q, q_idx_d;
  logic          valid_q, valid_d;

  logic [N-1:0]  spk;
  logic [N-1:0]  seen_all;
  logic [IW-1:0] low_idx;
  logic          fire;
  logic [IW-1:0] fire_idx;

  // Edge detection, winner selection and next-state computation.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    prev_d   = in_spk;
    seen_d   = seen_q;
    q_d      = q_q;
    q_time_d = q_time_q;
    q_idx_d  = q_idx_q;
    valid_d  = 1'b0;
    spk      = '0;
    low_idx  = '0;
    fire     = 1'b0;
    fire_idx = '0;

    // Only the first rising edge per channel counts, and only while armed.
    if (state_q == ARMED) begin
      spk = in_spk & ~prev_q & ~seen_q;
    end
    seen_all = seen_q | spk;

    // Lowest-index channel spiking on this edge (scan downward so lowest wins).
    for (int i = N - 1; i >= 0; i--) begin
      if (spk[i]) begin
        low_idx = IW'(i);
      end
    end

    case (mode_q)
      MODE_MIN: begin
        fire     = |spk;
        fire_idx = low_idx;
      end
      MODE_MAX: begin
        fire     = (|spk) && (&seen_all);
        fire_idx = low_idx;
      end
      MODE_INH: begin
        // Channel 0 must arrive strictly before every other channel.
        fire     = spk[0] && !(|seen_all[N-1:1]);
        fire_idx = '0;
      end
      default: begin
        fire     = 1'b0;
        fire_idx = '0;
      end
    endcase

    if (grst) begin
      state_d  = ARMED;
      cnt_d    = '0;
      mode_d   = mode;
      seen_d   = '0;
      q_d      = 1'b0;
      q_time_d = '1;
      q_idx_d  = '0;
      valid_d  = 1'b0;
    end else begin
      seen_d = seen_all;
      if (cnt_q != LAST_CNT) begin
        cnt_d = cnt_q + 1'b1;
      end
      if (state_q == ARMED && cnt_q == LAST_CNT) begin
        state_d = DONE;
        valid_d = 1'b1;
      end
      if (fire && !q_q) begin
        q_d      = 1'b1;
        q_time_d = cnt_q;
        q_idx_d  = fire_idx;
      end
    end
  end

  // State register; grst clears the cycle inside the combinational path.
  always_ff @(posedge aclk) begin
    state_q  <= state_d;
    cnt_q    <= cnt_d;
    mode_q   <= mode_d;
    prev_q   <= prev_d;
    seen_q   <= seen_d;
    q_q      <= q_d;
    q_time_q <= q_time_d;
    q_idx_q  <= q_idx_d;
    valid_q  <= valid_d;
  end

  assign q      = q_q;
  assign q_time = q_time_q;
  assign q_idx  = q_idx_q;
  assign valid  = valid_q;

endmodule
`default_nettype wire
